button_edge_debounce: RTL

- Input-conditioning stage between the raw push-button pin and the counter/display path.
- Synchronises the asynchronous button and debounces it with a stable-time filter.
- Produces a clean level plus one-cycle rise (pos) and fall (neg) pulses. The downstream counter increments on pos.
- Also emits a one-shot long-press pulse for hold-to-act features, e.g. counter clear.

---
 rtl/button_edge_debounce_if.sv | 28 ++
 rtl/button_edge_debounce.sv | 138 +++++++++++++
 2 files changed

// File: rtl/button_edge_debounce_if.sv
// Button conditioning bus: the raw button goes in, and the debounced level and edge pulses come out.
//   button     : raw asynchronous push-button (master -> slave)
//   level      : debounced button state (slave -> master)
//   pos / neg  : one-cycle pulses on the debounced rise / fall
//   long_press : one-cycle pulse once a press has been held long enough
interface button_edge_debounce_if;
    logic button;
    logic level;
    logic pos;
    logic neg;
    logic long_press;

    modport master (
        output button,
        input  level,
        input  pos,
        input  neg,
        input  long_press
    );

    modport slave (
        input  button,
        output level,
        output pos,
        output neg,
        output long_press
    );
endinterface

// File: rtl/button_edge_debounce.sv
// Push-button conditioning stage.
// This module synchronises the raw button with two flops and debounces it with a stable-time
// filter. It emits a clean level, one-cycle rise/fall pulses and a one-shot long-press pulse.
// Ports:
//   clk_i  : system clock, rising edge
//   rst_ni : asynchronous active-low reset
//   btn_io : button bus (slave side). The button comes in; level, pos, neg and long_press go out.
module button_edge_debounce #(
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES   = 100000000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    button_edge_debounce_if.slave btn_io
);

    localparam int unsigned StableW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned LongW   = $clog2(LONG_CYCLES + 1);

    localparam logic [StableW-1:0] StableMax = StableW'(STABLE_CYCLES);
    localparam logic [StableW-1:0] StableOne = StableW'(1);
    localparam logic [LongW-1:0]   LongLast  = LongW'(LONG_CYCLES - 1);
    localparam logic [LongW-1:0]   LongSat   = LongW'(LONG_CYCLES);
    localparam logic [LongW-1:0]   LongOne   = LongW'(1);

    typedef enum logic [1:0] {SLow, SRise, SHigh, SFall} state_e;

    logic               meta_q, sync_q;
    state_e             state_q;
    logic [StableW-1:0] stable_cnt_q;
    logic               level_q, pos_q, neg_q;
    logic [LongW-1:0]   hold_cnt_q;
    logic               long_q;
    logic               rise_done;

    // Two-flop synchroniser. Only sync_q feeds the filter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= btn_io.button;
            sync_q <= meta_q;
        end
    end

    // Stable-time filter. The pulses default low, so each one lasts exactly one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= SLow;
            stable_cnt_q <= '0;
            level_q      <= 1'b0;
            pos_q        <= 1'b0;
            neg_q        <= 1'b0;
        end else begin
            pos_q <= 1'b0;
            neg_q <= 1'b0;
            unique case (state_q)
                SLow: begin
                    if (sync_q) begin
                        state_q      <= SRise;
                        stable_cnt_q <= StableOne;
                    end else begin
                        stable_cnt_q <= '0;
                    end
                end
                SRise: begin
                    if (!sync_q) begin
                        // Glitch shorter than the filter window: drop it silently.
                        state_q      <= SLow;
                        stable_cnt_q <= '0;
                    end else if (stable_cnt_q == StableMax) begin
                        state_q      <= SHigh;
                        level_q      <= 1'b1;
                        pos_q        <= 1'b1;
                        stable_cnt_q <= '0;
                    end else begin
                        stable_cnt_q <= stable_cnt_q + StableOne;
                    end
                end
                SHigh: begin
                    if (!sync_q) begin
                        state_q      <= SFall;
                        stable_cnt_q <= StableOne;
                    end else begin
                        stable_cnt_q <= '0;
                    end
                end
                SFall: begin
                    if (sync_q) begin
                        state_q      <= SHigh;
                        stable_cnt_q <= '0;
                    end else if (stable_cnt_q == StableMax) begin
                        state_q      <= SLow;
                        level_q      <= 1'b0;
                        neg_q        <= 1'b1;
                        stable_cnt_q <= '0;
                    end else begin
                        stable_cnt_q <= stable_cnt_q + StableOne;
                    end
                end
                default: begin
                    state_q      <= SLow;
                    stable_cnt_q <= '0;
                    level_q      <= 1'b0;
                end
            endcase
        end
    end

    // The filter is accepting a rise at this edge, so pos goes high next cycle.
    assign rise_done = (state_q == SRise) && sync_q && (stable_cnt_q == StableMax);

    // Hold timer. It restarts on every accepted rise and saturates at LONG_CYCLES, so
    // long_press fires once per press and the count never wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (rise_done) begin
                hold_cnt_q <= '0;
            end else if (level_q && (hold_cnt_q != LongSat)) begin
                if (hold_cnt_q == LongLast) begin
                    long_q <= 1'b1;
                end
                hold_cnt_q <= hold_cnt_q + LongOne;
            end
        end
    end

    assign btn_io.level      = level_q;
    assign btn_io.pos        = pos_q;
    assign btn_io.neg        = neg_q;
    assign btn_io.long_press = long_q;

endmodule
